// File: rtl/max_stream_sched.sv
// Round-robin scheduler that shares one external combinational max unit between two
// burst requesters and returns one folded maximum per burst.
module max_stream_sched #(
    parameter int W     = 5,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0_valid,
    input  logic [W-1:0]     s0_data,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [W-1:0]     s1_data,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic [W-1:0]     cmp_a,
    output logic [W-1:0]     cmp_b,
    input  logic [W-1:0]     cmp_max,
    output logic             m_valid,
    output logic [W-1:0]     m_data,
    output logic             m_id,
    output logic [LEN_W-1:0] m_count,
    input  logic             m_ready,
    output logic [1:0]       dbg_state
);

    // Handshakes: a beat or result transfers on a rising edge where valid && ready.
    typedef enum logic [1:0] {IDLE, FIRST, ACC, DONE} state_t;

    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t          state;
    logic [W-1:0]    acc;
    logic [LEN_W-1:0] cnt;
    logic            gnt;
    logic            rr_last;

    logic            sel_valid;
    logic [W-1:0]    sel_data;
    logic            sel_last;
    logic            busy;

    always_comb begin
        sel_valid = gnt ? s1_valid : s0_valid;
        sel_data  = gnt ? s1_data  : s0_data;
        sel_last  = gnt ? s1_last  : s0_last;
        busy      = (state == FIRST) || (state == ACC);
    end

    always_comb begin
        s0_ready  = busy && !gnt;
        s1_ready  = busy && gnt;
        cmp_a     = (state == ACC) ? acc : '0;
        cmp_b     = (state == ACC) ? sel_data : '0;
        m_valid   = (state == DONE);
        m_data    = (state == DONE) ? acc : '0;
        m_id      = (state == DONE) && gnt;
        m_count   = (state == DONE) ? cnt : '0;
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            gnt     <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid || s1_valid) begin
                        // On a tie the requester that did not own the previous burst wins.
                        gnt   <= (s0_valid && s1_valid) ? !rr_last : s1_valid;
                        state <= FIRST;
                    end
                end
                FIRST: begin
                    if (sel_valid) begin
                        acc   <= sel_data;
                        cnt   <= CNT_ONE;
                        state <= sel_last ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (sel_valid) begin
                        acc <= cmp_max;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                        if (sel_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        rr_last <= gnt;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/max_stream_sched.md
# max_stream_sched

Shared-resource scheduler for the combinational max datapath: two requester streams each submit bursts of operands, the block grants the single max unit to one burst at a time with round-robin fairness, folds every beat through the unit, and returns one reduced maximum per burst. It sits between the requester interfaces and one instance of the max datapath, exact or approximate; the unit is external and driven combinationally through the `cmp_*` ports.

## Interface
- `W`, 5: operand/result width; matches the max datapath output width.
- `LEN_W`, 4: width of the beat counter reported with each result.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s0_valid`, `s1_valid`  in  1  requester beat valid.
- `s0_data`, `s1_data`  in  W  requester operand.
- `s0_last`, `s1_last`  in  1  final beat of the burst.
- `s0_ready`, `s1_ready`  out  1  beat accepted when valid && ready.
- `cmp_a`  out  W  max unit operand A (accumulator).
- `cmp_b`  out  W  max unit operand B (incoming beat).
- `cmp_max`  in  W  max unit result, combinational from `cmp_a`/`cmp_b`.
- `m_valid`  out  1  result valid.
- `m_data`  out  W  burst maximum.
- `m_id`  out  1  requester that owned the burst.
- `m_count`  out  LEN_W  beats in burst, saturating.
- `m_ready`  in  1  result consumer ready.

## Operation
- States: IDLE, FIRST, ACC, DONE.
- IDLE: if any `sX_valid`, register grant `gnt`. Both valid: the requester ≠ `rr_last` wins. One valid: that one wins. Go to FIRST. `s*_ready` = 0 in IDLE.
- FIRST: `sG_ready` = 1 (G = `gnt`), other ready = 0. On beat: `acc <= sG_data`, with no max unit use; `cnt <= 1`. If `last`, go to DONE, else ACC.
- ACC: `sG_ready` = 1. `cmp_a = acc`, `cmp_b = sG_data`. On beat: `acc <= cmp_max`, `cnt <= cnt+1`, saturating at 2^LEN_W−1. If `last`, go to DONE.
- Valid gaps in FIRST/ACC: wait and hold state. No timeout. No preemption; the grant is locked until `last` is accepted.
- DONE: `m_valid` = 1, with `m_data = acc`, `m_id = gnt`, `m_count = cnt`. All `s*_ready` = 0. On `m_ready`: `rr_last <= gnt`, go to IDLE.
- `cmp_a`/`cmp_b` = 0 in every state other than ACC.
- `cmp_max` is used unchecked. An approximate unit may return a value below either operand, and that value is accumulated as-is.
- `m_*` are registered and stable while `m_valid && !m_ready`.

## Timing
- Reset, checked at a clock edge with `rst_n` = 0:
  - state IDLE, `acc` = 0, `cnt` = 0, `gnt` = 0.
  - `rr_last` = 1, so requester 0 wins the first tie.
  - All outputs 0.
- Reset mid-burst or in DONE: the burst is discarded and no result is emitted. Requesters must restart the burst.
- Grant: valid seen in IDLE at cycle t → `sG_ready` = 1 at t+1.
- Throughput: one beat per cycle during FIRST/ACC.
- Result: last beat accepted at cycle t → `m_valid` = 1 at t+1.
- Handshake: `m_valid && m_ready` at cycle u → IDLE at u+1 → next ready at u+2 at the earliest.
- Minimum burst turnaround, one beat: 3 cycles with `m_ready` tied high.
- Requester validity: `sX_valid` may drop mid-burst. `sX_data`/`sX_last` must be stable while `valid && !ready`.

## Test plan
- Req0 burst 3, 7, 2 (last on 2), `m_ready` = 1 → `cmp_a`/`cmp_b` = (3,7) then (7,2). Result `m_data` = 7, `m_id` = 0, `m_count` = 3, `m_valid` one cycle after the last beat.
- Req1 single beat 9 with last → `m_data` = 9, `m_count` = 1, `cmp_a`/`cmp_b` = 0 throughout.
- Both requesters continuously valid with 2-beat bursts after reset → grants alternate 0, 1, 0, 1, and the `m_id` sequence matches. The non-granted ready is never 1.
- `m_ready` low for 4 cycles in DONE → `m_*` stable, both `s*_ready` = 0, and no beat is consumed.
- Req0 burst of 20 beats 0..19 with `LEN_W` = 4 → `m_count` = 15 (saturated), `m_data` = 19.
- `rst_n` low after 2 beats of a req0 burst → all outputs 0 next cycle and no `m_valid`. A fresh req1 burst of 4, 1 then yields `m_data` = 4, `m_id` = 1.
